// File: rtl/multi_edge_detector.sv
// multi_edge_detector: per-channel glitch-filtered edge detector with
// configurable detect mode, one-cycle edge pulses and sticky flags.
// Optional build macro MULTI_EDGE_DETECTOR_SYNC_EN inserts a two-flop
// synchroniser in front of each channel's sample (adds 2 cycles latency).

// One channel: optional synchroniser, glitch filter, edge pulse, sticky flag.
module multi_edge_detector_ch #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] filt_len,
    input  logic             clear,
    output logic             level,
    output logic             pulse,
    output logic             flag
);
    logic             sample;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             pulse_nxt;

`ifdef MULTI_EDGE_DETECTOR_SYNC_EN
    logic sync_q1, sync_q2;

    // Two-flop synchroniser for the asynchronous raw input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= sig;
            sync_q2 <= sync_q1;
        end
    end

    assign sample = sync_q2;
`else
    assign sample = sig;
`endif

    // A differing sample is accepted once it has already persisted filt_len
    // cycles; mode bit 0 enables rising pulses, bit 1 falling pulses.
    always_comb begin
        accept    = (sample != level) && (cnt >= filt_len);
        pulse_nxt = accept && ((sample && mode[0]) || (!sample && mode[1]));
    end

    // Filter counter, accepted level, edge pulse and sticky flag (set wins).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
            flag  <= 1'b0;
        end else begin
            pulse <= pulse_nxt;
            if (sample == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= sample;
                cnt   <= '0;
            end else begin
                // cnt < filt_len here, so the increment can never wrap
                cnt <= cnt + 1'b1;
            end
            if (pulse_nxt)
                flag <= 1'b1;
            else if (clear)
                flag <= 1'b0;
        end
    end
endmodule

// Top: NUM_CH independent channels sharing clock, reset and filt_len.
module multi_edge_detector #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     sig_in,
    input  logic [2*NUM_CH-1:0]   mode,
    input  logic [CNT_W-1:0]      filt_len,
    input  logic [NUM_CH-1:0]     clear,
    output logic [NUM_CH-1:0]     level_out,
    output logic [NUM_CH-1:0]     pulse_out,
    output logic [NUM_CH-1:0]     flag_out,
    output logic                  any_flag
);
    logic [NUM_CH-1:0][1:0] mode_ch;

    assign mode_ch = mode;

    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            multi_edge_detector_ch #(.CNT_W(CNT_W)) u_ch (
                .clk      (clk),
                .rst_n    (rst_n),
                .sig      (sig_in[i]),
                .mode     (mode_ch[i]),
                .filt_len (filt_len),
                .clear    (clear[i]),
                .level    (level_out[i]),
                .pulse    (pulse_out[i]),
                .flag     (flag_out[i])
            );
        end
    endgenerate

    assign any_flag = |flag_out;
endmodule
